// File: rtl/axi_slave_if.sv
// AXI4-Lite bus bundle between an SoC master and axi_slave.
//   AW: AWADDR, AWVALID, AWREADY     W: WDATA, WSTRB, WVALID, WREADY
//   B : BRESP, BVALID, BREADY        AR: ARADDR, ARVALID, ARREADY
//   R : RDATA, RRESP, RVALID, RREADY
// Modports: master (drives requests) and slave (drives responses).
interface axi_slave_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_slave.sv
// AXI4-Lite responder. Terminates the AW/W/B and AR/R channels and turns each
// transaction into a single-beat request on a simple peripheral register port.
// One outstanding transaction per direction; read and write run independently.
//
// Ports:
//   clk_i, rst_i            clock (AXI ACLK), synchronous active-high reset
//   axi                     AXI4-Lite slave modport (axi_slave_if.slave)
//   write_address_o/data_o/strobe_o, write_request_o   peripheral write request
//   write_done_i, write_error_i                        peripheral write completion
//   read_address_o, read_request_o                     peripheral read request
//   read_data_i, read_valid_i, read_error_i            peripheral read completion
//
// Optional build macro AXI_SLAVE_TIMEOUT_EN: when defined, a wait longer than
// TIMEOUT_CYCLES in W_WAIT/R_WAIT is answered with SLVERR.
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W beats (either order)
//   W_REQ  | write_request_o pulse to the peripheral
//   W_WAIT | waiting for write_done_i
//   W_RESP | BVALID held until BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for ARVALID
//   R_REQ  | read_request_o pulse to the peripheral
//   R_WAIT | waiting for read_valid_i
//   R_RESP | RVALID held until RREADY
module axi_slave #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE      = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    axi_slave_if.slave  axi,
    output logic [31:0] write_address_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  write_strobe_o,
    output logic        write_request_o,
    input  logic        write_done_i,
    input  logic        write_error_i,
    output logic [31:0] read_address_o,
    output logic        read_request_o,
    input  logic [31:0] read_data_i,
    input  logic        read_valid_i,
    input  logic        read_error_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic in_range(input logic [31:0] addr);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, ADDR_BASE};
        hi = lo + {1'b0, ADDR_SIZE};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

    // ------------------------------------------------------------------ write
    logic        aw_captured;
    logic        w_captured;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    // The capture flags stay set from capture until the B handshake, so READY
    // is low in every state except while that channel is still being waited for.
    assign axi.AWREADY = !aw_captured;
    assign axi.WREADY  = !w_captured;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_have;
    logic        w_have;
    logic [31:0] aw_addr_eff;
    logic [31:0] w_data_eff;
    logic [3:0]  w_strb_eff;

    // A beat arriving in the same cycle as the decision is used directly.
    assign aw_hs       = (w_state == W_IDLE) && axi.AWVALID && !aw_captured;
    assign w_hs        = (w_state == W_IDLE) && axi.WVALID && !w_captured;
    assign aw_have     = aw_captured || aw_hs;
    assign w_have      = w_captured || w_hs;
    assign aw_addr_eff = aw_captured ? aw_addr_q : axi.AWADDR;
    assign w_data_eff  = w_captured ? w_data_q : axi.WDATA;
    assign w_strb_eff  = w_captured ? w_strb_q : axi.WSTRB;

`ifdef AXI_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_cnt;
    // Leaving WAIT when the count would reach TIMEOUT_CYCLES puts RESP exactly
    // TIMEOUT_CYCLES cycles after WAIT entry.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state         <= W_IDLE;
            aw_captured     <= 1'b0;
            w_captured      <= 1'b0;
            aw_addr_q       <= '0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            axi.BVALID      <= 1'b0;
            axi.BRESP       <= RESP_OKAY;
            write_request_o <= 1'b0;
            write_address_o <= '0;
            write_data_o    <= '0;
            write_strobe_o  <= '0;
`ifdef AXI_SLAVE_TIMEOUT_EN
            w_cnt           <= '0;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_captured <= 1'b1;
                        aw_addr_q   <= axi.AWADDR;
                    end
                    if (w_hs) begin
                        w_captured <= 1'b1;
                        w_data_q   <= axi.WDATA;
                        w_strb_q   <= axi.WSTRB;
                    end
                    if (aw_have && w_have) begin
                        if (in_range(aw_addr_eff)) begin
                            w_state         <= W_REQ;
                            write_request_o <= 1'b1;
                            write_address_o <= aw_addr_eff - ADDR_BASE;
                            write_data_o    <= w_data_eff;
                            write_strobe_o  <= w_strb_eff;
`ifdef AXI_SLAVE_TIMEOUT_EN
                            w_cnt           <= '0;
`endif
                        end else begin
                            w_state    <= W_RESP;
                            axi.BVALID <= 1'b1;
                            axi.BRESP  <= RESP_DECERR;
                        end
                    end
                end
                W_REQ: begin
                    write_request_o <= 1'b0;
                    if (write_done_i) begin
                        w_state    <= W_RESP;
                        axi.BVALID <= 1'b1;
                        axi.BRESP  <= write_error_i ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (write_done_i) begin
                        w_state    <= W_RESP;
                        axi.BVALID <= 1'b1;
                        axi.BRESP  <= write_error_i ? RESP_SLVERR : RESP_OKAY;
                    end
`ifdef AXI_SLAVE_TIMEOUT_EN
                    else if (w_cnt == CNT_LAST) begin
                        w_state    <= W_RESP;
                        axi.BVALID <= 1'b1;
                        axi.BRESP  <= RESP_SLVERR;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                    end
`endif
                end
                W_RESP: begin
                    if (axi.BREADY) begin
                        w_state     <= W_IDLE;
                        axi.BVALID  <= 1'b0;
                        aw_captured <= 1'b0;
                        w_captured  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= R_IDLE;
            axi.ARREADY    <= 1'b1;
            axi.RVALID     <= 1'b0;
            axi.RRESP      <= RESP_OKAY;
            axi.RDATA      <= '0;
            read_request_o <= 1'b0;
            read_address_o <= '0;
`ifdef AXI_SLAVE_TIMEOUT_EN
            r_cnt          <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.ARVALID) begin
                        axi.ARREADY <= 1'b0;
                        if (in_range(axi.ARADDR)) begin
                            r_state        <= R_REQ;
                            read_request_o <= 1'b1;
                            read_address_o <= axi.ARADDR - ADDR_BASE;
`ifdef AXI_SLAVE_TIMEOUT_EN
                            r_cnt          <= '0;
`endif
                        end else begin
                            r_state    <= R_RESP;
                            axi.RVALID <= 1'b1;
                            axi.RRESP  <= RESP_DECERR;
                            axi.RDATA  <= '0;
                        end
                    end
                end
                R_REQ: begin
                    read_request_o <= 1'b0;
                    if (read_valid_i) begin
                        r_state    <= R_RESP;
                        axi.RVALID <= 1'b1;
                        axi.RDATA  <= read_data_i;
                        axi.RRESP  <= read_error_i ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (read_valid_i) begin
                        r_state    <= R_RESP;
                        axi.RVALID <= 1'b1;
                        axi.RDATA  <= read_data_i;
                        axi.RRESP  <= read_error_i ? RESP_SLVERR : RESP_OKAY;
                    end
`ifdef AXI_SLAVE_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        r_state    <= R_RESP;
                        axi.RVALID <= 1'b1;
                        axi.RDATA  <= '0;
                        axi.RRESP  <= RESP_SLVERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                R_RESP: begin
                    if (axi.RREADY) begin
                        r_state     <= R_IDLE;
                        axi.RVALID  <= 1'b0;
                        axi.ARREADY <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_slave.md
Name: axi_slave

Overview:
- AXI4-Lite responder: the slave-side counterpart of the SoC bus master. It terminates independent write (AW/W/B) and read (AR/R) channels and converts each transaction into a single-beat request on a simple peripheral register port.
- Instantiated in front of every memory-mapped peripheral (UART, timers, GPIO).
- Performs address-window decoding and drives AXI response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- One outstanding transaction per direction; the read and write paths run concurrently and independently.

Parameters:
- ADDR_BASE, 32'h0000_0000, first byte address owned by the slave.
- ADDR_SIZE, 32'h0000_1000, window size in bytes. A request is in range when ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE (unsigned, 33-bit compare, so no wrap).
- TIMEOUT_CYCLES, 256, peripheral response deadline; used only with the optional feature.

Ports:
- clk_i in 1: clock, shared with the AXI ACLK.
- rst_i in 1: synchronous, active-high reset.
- AWADDR in 32, AWVALID in 1, AWREADY out 1: write address channel.
- WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
- BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
- ARADDR in 32, ARVALID in 1, ARREADY out 1: read address channel.
- RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
- write_address_o out 32, write_data_o out 32, write_strobe_o out 4: peripheral write request fields. Address is the offset (addr - ADDR_BASE).
- write_request_o out 1: one-cycle write request pulse.
- write_done_i in 1, write_error_i in 1: peripheral write completion; error sampled with done.
- read_address_o out 32: peripheral read offset.
- read_request_o out 1: one-cycle read request pulse.
- read_data_i in 32, read_valid_i in 1, read_error_i in 1: peripheral read completion.

Behaviour:
- Reset:
  - AWREADY, WREADY and ARREADY are 1. BVALID, RVALID, write_request_o and read_request_o are 0.
  - BRESP, RRESP and RDATA are 0. Address and data outputs are 0.
  - Both FSMs return to IDLE. Reset mid-transaction drops the transaction silently: no B or R beat is produced.
- Write FSM states: W_IDLE, W_REQ, W_WAIT, W_RESP.
  - W_IDLE: AWREADY = !aw_captured, WREADY = !w_captured.
  - AW and W are captured independently, in either order or in the same cycle, each on VALID&READY. A channel's READY drops after its capture.
  - When both are captured: in-range → W_REQ; out-of-range → W_RESP with BRESP=DECERR, no peripheral request issued.
  - W_REQ: write_request_o=1 for exactly one cycle. If write_done_i is high in this cycle → W_RESP; otherwise → W_WAIT.
  - W_WAIT: hold until write_done_i → W_RESP. BRESP = write_error_i ? SLVERR : OKAY.
  - W_RESP: BVALID=1, with BRESP stable until BREADY. On BVALID&BREADY → W_IDLE with both capture flags cleared, and AWREADY/WREADY return to 1 the next cycle.
  - Minimum latency: AW+W handshake in cycle 0, request in cycle 1, done in cycle 1, BVALID in cycle 2.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: ARREADY=1. On ARVALID: in-range → R_REQ; out-of-range → R_RESP with RRESP=DECERR and RDATA=0.
  - R_REQ: read_request_o=1 for one cycle. If read_valid_i is high in this cycle → R_RESP; otherwise → R_WAIT.
  - On read_valid_i, register RDATA=read_data_i and RRESP = read_error_i ? SLVERR : OKAY.
  - R_RESP: RVALID=1, with RDATA and RRESP stable until RREADY. On RVALID&RREADY → R_IDLE.
  - ARREADY is 0 in every state except R_IDLE.
- Ignored peripheral inputs: write_done_i outside W_REQ/W_WAIT and read_valid_i outside R_REQ/R_WAIT are ignored.
- Concurrency: simultaneous read and write requests are both issued the same cycle. The peripheral must accept both.
- Stability: AXI outputs never change while VALID is high and READY is low.

Optional Feature:
- Macro: AXI_SLAVE_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) per direction clears on entry to W_REQ/R_REQ and increments each cycle in W_WAIT/R_WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM enters W_RESP/R_RESP with SLVERR (RDATA=0).
  - A late done_i or valid_i after timeout is ignored.
- When undefined: no counters exist and W_WAIT/R_WAIT wait indefinitely.

Test Plan:
- Write in range: AW 0x0000_0010 with W 0xDEAD_BEEF, strobe 0xF, same cycle; done 2 cycles after request → one write_request_o pulse with offset 0x10 and data 0xDEADBEEF; BVALID with BRESP=00; AWREADY/WREADY return to 1 after BREADY.
- W before AW: WVALID in cycle 0, AWVALID in cycle 3 → WREADY low in cycles 1-3; request issued in cycle 4 with the correct pairing.
- Out-of-range: ARADDR 0x0000_2000 with ADDR_SIZE 0x1000 → no read_request_o; RVALID with RRESP=11 and RDATA=0.
- Read with error and backpressure: read_valid_i with read_data_i 0x1234_5678 and read_error_i=1; RREADY held low 5 cycles → RDATA/RRESP=10 stable throughout; ARREADY=0 until the handshake.
- Concurrent read and write, plus reset mid-W_WAIT: both requests pulse the same cycle; assert rst_i during W_WAIT → BVALID stays 0 and all outputs return to reset values.
- Timeout (AXI_SLAVE_TIMEOUT_EN, TIMEOUT_CYCLES=8): no write_done_i → BVALID with BRESP=10 eight cycles after W_WAIT entry; a later write_done_i is ignored.
